// File: rtl/fpu_cvt_unit.sv
// fpu_cvt_unit
// Multi-cycle integer <-> single-precision conversion unit for RV32F
// (FCVT.W.S, FCVT.WU.S, FCVT.S.W, FCVT.S.WU). A one-bit-per-cycle shifter
// aligns (float->int) or normalises (int->float) the operand, then a single
// cycle rounds and packs the result.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request, sampled only while busy=0 (IDLE or DONE)
//   cvt_op  00 W.S, 01 WU.S, 10 S.W, 11 S.WU
//   funct3  rounding mode: 001 = RTZ, anything else = RNE
//   rs1     source operand (float bits or integer)
//   result  converted value, held until the next accepted start
//   fflags  {NV,DZ,OF,UF,NX}; DZ/OF/UF are always 0
//   busy    high in SHIFT and ROUND
//   done    one-cycle pulse, result/fflags valid in that cycle
module fpu_cvt_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cvt_op,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  output logic [31:0] result,
  output logic [4:0]  fflags,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic        rtz_q;
  logic        sgn_q;
  logic [31:0] acc;
  logic        grd;
  logic        stk;
  logic [5:0]  cnt;
  logic [5:0]  n_q;
  logic        spec_q;
  logic [31:0] spec_res_q;
  logic [4:0]  spec_fl_q;

  // Setup values derived from the live operand; only used on the accepting edge.
  logic [31:0] s_acc;
  logic [5:0]  s_n;
  logic        s_spec;
  logic [31:0] s_res;
  logic [4:0]  s_fl;

  // Rounding/packing results for the ROUND cycle.
  logic [31:0] r_res;
  logic [4:0]  r_fl;

  logic [7:0]  e;
  logic        f2i;
  logic        is_w;

  function automatic logic [5:0] lzc(input logic [31:0] v);
    lzc = 6'd32;
    for (int i = 0; i < 32; i++)
      if (v[i]) lzc = 6'(31 - i);
  endfunction

  assign e    = rs1[30:23];
  assign f2i  = ~cvt_op[1];
  assign is_w = ~cvt_op[0];

  // Operand setup and special-case detection. Specials start with n=0 so
  // they go straight to ROUND, where the forced result is packed.
  always_comb begin
    s_acc  = '0;
    s_n    = '0;
    s_spec = 1'b0;
    s_res  = '0;
    s_fl   = '0;
    if (f2i) begin
      s_acc = {1'b1, rs1[22:0], 8'b0};
      s_n   = 6'(8'd158 - e);
      if (e == 8'hFF && rs1[22:0] != '0) begin
        s_spec = 1'b1;
        s_res  = is_w ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
        s_fl   = 5'b10000;
      end else if (e == 8'hFF) begin
        s_spec = 1'b1;
        if (rs1[31]) s_res = is_w ? 32'h8000_0000 : 32'h0000_0000;
        else         s_res = is_w ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
        s_fl   = 5'b10000;
      end else if (is_w && e >= 8'd158) begin
        s_spec = 1'b1;
        if (rs1 == 32'hCF00_0000) begin
          s_res = 32'h8000_0000;
        end else begin
          s_res = rs1[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          s_fl  = 5'b10000;
        end
      end else if (!is_w && e >= 8'd159) begin
        // Negative operands this large are far below zero: invalid too.
        s_spec = 1'b1;
        s_res  = rs1[31] ? 32'h0000_0000 : 32'hFFFF_FFFF;
        s_fl   = 5'b10000;
      end else if (e < 8'd126) begin
        s_spec = 1'b1;
        s_res  = '0;
        s_fl   = {4'b0, |rs1[30:0]};
      end
      if (s_spec) s_n = '0;
    end else begin
      // 0x80000000 negates to itself, which is the correct magnitude.
      s_acc = (is_w && rs1[31]) ? (32'd0 - rs1) : rs1;
      if (rs1 == '0) s_spec = 1'b1;
      else           s_n    = lzc(s_acc);
    end
  end

  logic        f_inc;
  logic [31:0] f_sum;
  logic        i_grd;
  logic        i_stk;
  logic        i_inc;
  logic [23:0] i_msum;
  logic [7:0]  i_exp;

  // Round and pack. Float->int rounds the aligned accumulator using the
  // shifted-out guard/sticky; int->float rounds the normalised magnitude.
  always_comb begin
    f_inc  = ~rtz_q & grd & (stk | acc[0]);
    f_sum  = acc + {31'b0, f_inc};
    i_grd  = acc[7];
    i_stk  = |acc[6:0];
    i_inc  = ~rtz_q & i_grd & (i_stk | acc[8]);
    i_msum = {1'b0, acc[30:8]} + {23'b0, i_inc};
    i_exp  = 8'd158 - {2'b0, n_q} + {7'b0, i_msum[23]};
    r_res  = '0;
    r_fl   = '0;
    if (spec_q) begin
      r_res = spec_res_q;
      r_fl  = spec_fl_q;
    end else if (!op_q[1]) begin
      if (!op_q[0]) begin
        r_res = sgn_q ? (32'd0 - f_sum) : f_sum;
        r_fl  = {4'b0, grd | stk};
      end else if (sgn_q) begin
        r_res = '0;
        if (f_sum != '0) r_fl = 5'b10000;
        else             r_fl = {4'b0, grd | stk};
      end else begin
        r_res = f_sum;
        r_fl  = {4'b0, grd | stk};
      end
    end else begin
      // On mantissa carry the 24-bit sum wraps its low 23 bits to zero.
      r_res = {sgn_q & ~op_q[0], i_exp, i_msum[22:0]};
      r_fl  = {4'b0, i_grd | i_stk};
    end
  end

  // Control FSM and datapath registers. A start is accepted in IDLE and in
  // DONE, which gives back-to-back operation without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      result     <= '0;
      fflags     <= '0;
      op_q       <= '0;
      rtz_q      <= 1'b0;
      sgn_q      <= 1'b0;
      acc        <= '0;
      grd        <= 1'b0;
      stk        <= 1'b0;
      cnt        <= '0;
      n_q        <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_fl_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q       <= cvt_op;
            rtz_q      <= (funct3 == 3'b001);
            sgn_q      <= rs1[31];
            acc        <= s_acc;
            grd        <= 1'b0;
            stk        <= 1'b0;
            cnt        <= s_n;
            n_q        <= s_n;
            spec_q     <= s_spec;
            spec_res_q <= s_res;
            spec_fl_q  <= s_fl;
            state      <= (s_n == '0) ? ROUND : SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (!op_q[1]) begin
            acc <= {1'b0, acc[31:1]};
            grd <= acc[0];
            stk <= stk | grd;
          end else begin
            acc <= {acc[30:0], 1'b0};
          end
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= ROUND;
        end
        ROUND: begin
          result <= r_res;
          fflags <= r_fl;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT) || (state == ROUND);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fpu_cvt_unit.sv
// tb_fpu_cvt_unit
// Scoreboard bench for fpu_cvt_unit: each launched conversion pushes its
// expected result, flags and start-to-done latency; the scenario task pops
// and compares when done pulses.
module tb_fpu_cvt_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cvt_op;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fpu_cvt_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cvt_op (cvt_op),
    .funct3 (funct3),
    .rs1    (rs1),
    .result (result),
    .fflags (fflags),
    .busy   (busy),
    .done   (done)
  );

  // Reference model built on 64-bit integer arithmetic.
  function automatic void ref_model(input logic [1:0] op, input logic [2:0] rm,
                                    input logic [31:0] x, output logic [31:0] res,
                                    output logic [4:0] fl, output int lat);
    bit rtz;
    bit up;
    bit neg;
    bit inexact;
    logic [63:0] sig, ip, rem, half, mag, q;
    int ex, p, sh;
    rtz = (rm == 3'b001);
    res = '0;
    fl  = '0;
    lat = 2;
    rem = '0;
    if (!op[1]) begin
      ex = int'(x[30:23]);
      if (ex == 255) begin
        fl = 5'b10000;
        if (x[22:0] != '0 || !x[31]) res = op[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        else                          res = op[0] ? 32'h0 : 32'h8000_0000;
      end else if (ex < 126) begin
        res = '0;
        fl  = (x[30:0] != '0) ? 5'b00001 : 5'b00000;
      end else begin
        lat = ((op == 2'b00 && ex >= 158) || (op == 2'b01 && ex >= 159)) ? 2 : 160 - ex;
        sig = {40'b0, 1'b1, x[22:0]};
        if (ex >= 190) begin
          ip = '1;
        end else if (ex >= 150) begin
          ip = sig << (ex - 150);
        end else begin
          sh   = 150 - ex;
          ip   = sig >> sh;
          rem  = sig & ((64'd1 << sh) - 64'd1);
          half = 64'd1 << (sh - 1);
          up   = !rtz && (rem > half || (rem == half && ip[0]));
          ip   = ip + {63'b0, up};
        end
        inexact = (rem != '0);
        if (op == 2'b00) begin
          if (x[31]) begin
            if (ip > 64'h8000_0000) begin res = 32'h8000_0000; fl = 5'b10000; end
            else begin res = 32'd0 - ip[31:0]; fl = {4'b0, inexact}; end
          end else if (ip > 64'h7FFF_FFFF) begin
            res = 32'h7FFF_FFFF; fl = 5'b10000;
          end else begin
            res = ip[31:0]; fl = {4'b0, inexact};
          end
        end else begin
          if (x[31]) begin
            res = '0;
            fl  = (ip != '0) ? 5'b10000 : {4'b0, inexact};
          end else if (ip > 64'hFFFF_FFFF) begin
            res = 32'hFFFF_FFFF; fl = 5'b10000;
          end else begin
            res = ip[31:0]; fl = {4'b0, inexact};
          end
        end
      end
    end else begin
      neg = !op[0] && x[31];
      mag = {32'b0, neg ? (32'd0 - x) : x};
      if (mag != '0) begin
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        lat = 33 - p;
        if (p <= 23) begin
          q = mag << (23 - p);
        end else begin
          sh   = p - 23;
          q    = mag >> sh;
          rem  = mag & ((64'd1 << sh) - 64'd1);
          half = 64'd1 << (sh - 1);
          up   = !rtz && (rem > half || (rem == half && q[0]));
          q    = q + {63'b0, up};
          if (q[24]) begin q = q >> 1; p = p + 1; end
        end
        res = {neg, 8'(127 + p), q[22:0]};
        fl  = (rem != '0) ? 5'b00001 : 5'b00000;
      end
    end
  endfunction

  // Drive one request for a single edge and record what it should produce.
  // Inputs are scrambled afterwards so an operation in flight must rely on
  // its captured operands.
  task automatic launch(input logic [1:0] op, input logic [2:0] rm, input logic [31:0] x,
                        input logic [31:0] eres, input logic [4:0] efl, input int elat);
    exp_t t;
    cvt_op = op;
    funct3 = rm;
    rs1    = x;
    start  = 1'b1;
    t.res  = eres;
    t.fl   = efl;
    t.lat  = elat;
    sb.push_back(t);
    @(posedge clk); #1;
    start  = 1'b0;
    rs1    = $urandom;
    cvt_op = 2'($urandom);
    funct3 = 3'($urandom);
  endtask

  // Advance cycle by cycle until done, bounded; cyc is the cycle number
  // counted from the accepting edge.
  task automatic wait_done(input int cyc0, output int cyc, output bit timed_out);
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cvt_op = '0; funct3 = '0; rs1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h expected %h", result, 32'h0); end
    checks++; if (fflags !== 5'h0) begin errors++; $display("[TB] FAIL reset_fflags got %b expected %b", fflags, 5'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
  endtask

  task automatic test_vectors();
    logic [1:0]  ops[11]  = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    logic [2:0]  rms[11]  = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [31:0] xs[11]   = '{32'h0000_0007, 32'hC0CC_CCCD, 32'h4020_0000, 32'h404C_CCCD, 32'h7FFF_FFFF,
                              32'h7FFF_FFFF, 32'h8000_0000, 32'h7FC0_0000, 32'hBF80_0000, 32'hBECC_CCCD, 32'h4F00_0000};
    logic [31:0] ress[11] = '{32'h40E0_0000, 32'hFFFF_FFFA, 32'h0000_0002, 32'h0000_0003, 32'h4F00_0000,
                              32'h4EFF_FFFF, 32'hCF00_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
    logic [4:0]  fls[11]  = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001,
                              5'b00001, 5'b00000, 5'b10000, 5'b10000, 5'b00001, 5'b10000};
    int          lats[11] = '{31, 31, 32, 32, 3, 3, 2, 2, 33, 2, 2};
    exp_t t;
    int   cyc;
    bit   to;
    for (int i = 0; i < 11; i++) begin
      launch(ops[i], rms[i], xs[i], ress[i], fls[i], lats[i]);
      wait_done(1, cyc, to);
      t = sb.pop_front();
      checks++;
      if (to) begin
        errors++; $display("[TB] FAIL vec%0d timeout got no done expected done at %0d", i, t.lat);
      end else begin
        if (result !== t.res) begin errors++; $display("[TB] FAIL vec%0d result got %h expected %h", i, result, t.res); end
        checks++; if (fflags !== t.fl) begin errors++; $display("[TB] FAIL vec%0d fflags got %b expected %b", i, fflags, t.fl); end
        checks++; if (cyc !== t.lat) begin errors++; $display("[TB] FAIL vec%0d latency got %0d expected %0d", i, cyc, t.lat); end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [2:0]  rm;
    logic [31:0] x, r;
    logic [4:0]  f;
    int          l, ee, cyc;
    bit          to;
    exp_t        t;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      rm = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
      if (!op[1]) begin
        if ($urandom_range(0, 9) == 0) ee = ($urandom_range(0, 1) == 1) ? 255 : 0;
        else                           ee = $urandom_range(115, 162);
        x = {1'($urandom), 8'(ee), 23'($urandom)};
      end else begin
        x = $urandom >> $urandom_range(0, 31);
      end
      ref_model(op, rm, x, r, f, l);
      launch(op, rm, x, r, f, l);
      wait_done(1, cyc, to);
      t = sb.pop_front();
      checks++;
      if (to) begin
        errors++; $display("[TB] FAIL rnd%0d timeout op=%b x=%h got no done expected done", i, op, x);
      end else begin
        if (result !== t.res) begin errors++; $display("[TB] FAIL rnd%0d result op=%b rm=%b x=%h got %h expected %h", i, op, rm, x, result, t.res); end
        checks++; if (fflags !== t.fl) begin errors++; $display("[TB] FAIL rnd%0d fflags op=%b x=%h got %b expected %b", i, op, x, fflags, t.fl); end
        checks++; if (cyc !== t.lat) begin errors++; $display("[TB] FAIL rnd%0d latency op=%b x=%h got %0d expected %0d", i, op, x, cyc, t.lat); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops[4] = '{2'b11, 2'b00, 2'b10, 2'b01};
    logic [31:0] xs[4]  = '{32'h0000_0100, 32'hC2F6_0000, 32'hFFFF_FF00, 32'h4B80_0001};
    logic [31:0] r;
    logic [4:0]  f;
    int          l, cyc;
    bit          to;
    exp_t        t;
    ref_model(ops[0], 3'b000, xs[0], r, f, l);
    launch(ops[0], 3'b000, xs[0], r, f, l);
    for (int i = 0; i < 4; i++) begin
      wait_done(1, cyc, to);
      t = sb.pop_front();
      checks++;
      if (to) begin
        errors++; $display("[TB] FAIL b2b%0d timeout got no done expected done", i);
      end else begin
        if (result !== t.res) begin errors++; $display("[TB] FAIL b2b%0d result got %h expected %h", i, result, t.res); end
        checks++; if (fflags !== t.fl) begin errors++; $display("[TB] FAIL b2b%0d fflags got %b expected %b", i, fflags, t.fl); end
        checks++; if (cyc !== t.lat) begin errors++; $display("[TB] FAIL b2b%0d latency got %0d expected %0d", i, cyc, t.lat); end
      end
      // Next request is driven while done is still high.
      if (i < 3 && !to) begin
        ref_model(ops[i+1], 3'b000, xs[i+1], r, f, l);
        launch(ops[i+1], 3'b000, xs[i+1], r, f, l);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int   cyc, extra;
    bit   to;
    exp_t t;
    launch(2'b10, 3'b000, 32'h0000_0007, 32'h40E0_0000, 5'b00000, 31);
    cyc = 1;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid got %b expected 1", busy); end
    start = 1'b1; cvt_op = 2'b00; funct3 = 3'b000; rs1 = 32'h3F80_0000;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    wait_done(cyc, cyc, to);
    t = sb.pop_front();
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL busy_ign timeout got no done expected done");
    end else begin
      if (result !== t.res) begin errors++; $display("[TB] FAIL busy_ign result got %h expected %h", result, t.res); end
      checks++; if (cyc !== t.lat) begin errors++; $display("[TB] FAIL busy_ign latency got %0d expected %0d", cyc, t.lat); end
    end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL busy_queued activity cycles got %0d expected 0", extra); end
  endtask

  task automatic test_reset_abort();
    int   cyc, extra;
    bit   to;
    exp_t t;
    launch(2'b10, 3'b000, 32'h0000_0007, 32'h40E0_0000, 5'b00000, 31);
    cyc = 1;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_front());
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL abort_result got %h expected %h", result, 32'h0); end
    checks++; if (fflags !== 5'h0) begin errors++; $display("[TB] FAIL abort_fflags got %b expected %b", fflags, 5'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b expected 0", done); end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL abort_done_pulse count got %0d expected 0", extra); end
    launch(2'b00, 3'b000, 32'h4020_0000, 32'h0000_0002, 5'b00001, 32);
    wait_done(1, cyc, to);
    t = sb.pop_front();
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL post_abort timeout got no done expected done");
    end else begin
      if (result !== t.res) begin errors++; $display("[TB] FAIL post_abort result got %h expected %h", result, t.res); end
      checks++; if (fflags !== t.fl) begin errors++; $display("[TB] FAIL post_abort fflags got %b expected %b", fflags, t.fl); end
      checks++; if (cyc !== t.lat) begin errors++; $display("[TB] FAIL post_abort latency got %0d expected %0d", cyc, t.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_left got %0d expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fpu_cvt_unit.md
# fpu_cvt_unit

Multi-cycle integer/single-precision conversion unit for the RV32F datapath, covering FCVT.W.S, FCVT.WU.S, FCVT.S.W and FCVT.S.WU. Conversion runs in both directions: float-to-integer and integer-to-float. It sits beside the combinational FPU on the same rs1/funct3 operand path and uses a start/busy/done handshake. Internally a one-bit-per-cycle shifter does alignment and normalisation, followed by a single rounding/packing cycle.

## Interface
Parameters: none.

- clk  in  1  rising-edge clock (the single clock domain)
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- cvt_op  in  2  00 FCVT.W.S, 01 FCVT.WU.S, 10 FCVT.S.W, 11 FCVT.S.WU
- funct3  in  3  rounding mode: 001 = RTZ, any other value = RNE
- rs1  in  32  source operand (float bits or integer)
- result  out  32  converted value; held until the next accepted start
- fflags  out  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0
- busy  out  1  high in SHIFT and ROUND
- done  out  1  one-cycle pulse; result and fflags are valid in that cycle

## Operation
- FSM states and transitions:
  - IDLE: on start, go to SHIFT; if the shift count n=0, go directly to ROUND.
  - SHIFT: go to ROUND when the count reaches 0.
  - ROUND: go to DONE.
  - DONE: go to IDLE. A new start is accepted in DONE.
- Operand capture: rs1, cvt_op and funct3 are latched on the accepting edge. Later changes to the inputs do not affect an operation in flight.
- Float-to-int setup (e = rs1[30:23], m = {1, rs1[22:0]}):
  - acc = {m, 8'b0}, guard = 0, sticky = 0, n = 158 - e.
  - Special cases set n = 0 and force the result:
    - NaN: 0x7FFFFFFF (W) or 0xFFFFFFFF (WU), NV.
    - +inf: saturate high (0x7FFFFFFF for W, 0xFFFFFFFF for WU), NV.
    - -inf: saturate low (0x80000000 for W, 0 for WU), NV.
    - W with e >= 158: 0x80000000 with no flag if the input is exactly -2^31 (0xCF000000); otherwise saturate by sign, NV.
    - WU with sign=0 and e >= 159: 0xFFFFFFFF, NV.
    - e < 126: result 0. NX is set unless the input is +/-0.
- Float-to-int SHIFT: each cycle, acc is shifted right by 1; guard takes the bit shifted out and sticky accumulates the old guard. n ranges 0..32.
- Int-to-float setup: mag = |rs1| for W (0x80000000 maps to itself), rs1 for WU.
  - Zero input: result 0x00000000, n = 0.
  - Otherwise n = leading-zero count of mag (0..31).
- Int-to-float SHIFT: each cycle, mag is shifted left by 1.
- ROUND, float-to-int:
  - RNE increments acc if guard && (sticky || acc[0]). RTZ never increments.
  - W with sign=1: result = -acc.
  - WU with sign=1: if acc != 0, result is 0 with NV; otherwise result is 0.
  - NX = guard | sticky, suppressed whenever NV is set.
- ROUND, int-to-float:
  - Fields: exp = 158 - n, mant = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Rounding follows the same RNE/RTZ rule.
  - If the mantissa carries out, exp increments and mant becomes 0.
  - Sign = rs1[31] for W, 0 for WU.
  - NX = guard | sticky.
- Special-case results are forced in ROUND; no shifting occurs for them.

## Timing
- Reset values: result = 0, fflags = 0, busy = 0, done = 0, state IDLE.
- Latency: start is accepted at edge 0, SHIFT occupies cycles 1..n, ROUND is cycle n+1, and done=1 in cycle n+2. Total start-to-done latency is n+2 cycles: minimum 2, maximum 34.
- start while busy=1 is ignored and does not queue.
- start in the DONE cycle is accepted, so back-to-back throughput is n+2 cycles per operation.
- result and fflags update only on the edge that enters DONE.
- rst asserted mid-operation aborts the conversion on that edge and restores all reset values. No done pulse is produced for the aborted operation.
- rst has priority over start.

## Test plan
- FCVT.S.W, rs1 = 7 -> n = 29, done at cycle 31, result 0x40E00000, fflags 0.
- FCVT.W.S with RNE:
  - 0xC0CCCCCD (-6.4) -> 0xFFFFFFFA, NX.
  - 0x40200000 (2.5) -> 0x00000002, NX (tie rounds to even).
  - 0x404CCCCD (3.2) with RTZ -> 3, NX, done at cycle 32.
- FCVT.S.W rounding and exact cases:
  - 0x7FFFFFFF with RNE -> 0x4F000000, NX (mantissa carry).
  - 0x7FFFFFFF with RTZ -> 0x4EFFFFFF, NX.
  - 0x80000000 -> 0xCF000000 with no flags, done at cycle 2.
- Specials:
  - FCVT.W.S of NaN 0x7FC00000 -> 0x7FFFFFFF, NV.
  - FCVT.WU.S of 0xBF800000 (-1.0) -> 0, NV.
  - FCVT.WU.S of 0xBECCCCCD (-0.4) -> 0, NX only.
  - FCVT.W.S of 0x4F000000 -> 0x7FFFFFFF, NV.
- Handshake: a start pulse during busy is ignored. A start in the DONE cycle is accepted and its done follows n+2 cycles later. rst pulsed at cycle 10 of a 31-cycle operation -> no done, all outputs 0, and the next start completes normally.
